pipe_hazard_ctrl: RTL and testbench

Central pipeline interlock and forwarding controller for the 5-stage NPC core (IF/ID/EX/MEM/WB).
- Compares ID source registers against in-flight EX/MEM/WB destinations and generates per-operand forward selects.
- Inserts load-use bubbles and freezes the pipe while data memory is busy.
- Sequences branch/jump redirect flushes, including redirects that arrive during a memory wait.
- Sits beside the stage registers, replacing the ad-hoc ID-stage stall logic.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 18 +
 rtl/pipe_hazard_ctrl_fwd_sel.sv | 50 +++++
 rtl/pipe_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared constants for the pipeline hazard controller
package pipe_hazard_ctrl_pkg;

  // Register address width of the core register file
  localparam int REG_ADDR_WIDTH = 5;

  // Operand source selects driven to the EX-stage operand muxes
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  // Controller state encodings
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_TIMEOUT  = 2'd2;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// rtl/pipe_hazard_ctrl_fwd_sel.sv - per-operand match and forward priority select
module hazard_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int AW = REG_ADDR_WIDTH
) (
  input  logic          id_valid,
  input  logic [AW-1:0] rs,
  input  logic          use_rs,
  input  logic          ex_valid,
  input  logic          ex_wen,
  input  logic          ex_is_load,
  input  logic [AW-1:0] ex_rd,
  input  logic          mem_valid,
  input  logic          mem_wen,
  input  logic          mem_is_load,
  input  logic          mem_ready,
  input  logic [AW-1:0] mem_rd,
  input  logic          wb_valid,
  input  logic          wb_wen,
  input  logic [AW-1:0] wb_rd,
  output logic [1:0]    fwd,
  output logic          load_use
);

  logic rd_live;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign rd_live = id_valid & use_rs;
  assign ex_hit  = rd_live & ex_valid  & ex_wen  & (ex_rd  != '0) & (ex_rd  == rs);
  assign mem_hit = rd_live & mem_valid & mem_wen & (mem_rd != '0) & (mem_rd == rs);
  assign wb_hit  = rd_live & wb_valid  & wb_wen  & (wb_rd  != '0) & (wb_rd  == rs);

  // Youngest producer wins; an unavailable load value shadows older producers (pipe stalls anyway)
  always_comb begin
    fwd      = FWD_RF;
    load_use = 1'b0;
    if (ex_hit) begin
      if (ex_is_load) load_use = 1'b1;
      else            fwd      = FWD_EX;
    end else if (mem_hit) begin
      if (!mem_is_load || mem_ready) fwd = FWD_MEM;
    end else if (wb_hit) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline interlock, forwarding and redirect-flush controller
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = pipe_hazard_ctrl_pkg::REG_ADDR_WIDTH,
  parameter int TIMEOUT_W      = 8,
  parameter int PERF_W         = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic                      ex_valid,
  input  logic                      ex_wen,
  input  logic                      ex_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      mem_valid,
  input  logic                      mem_wen,
  input  logic                      mem_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  input  logic                      wb_valid,
  input  logic                      wb_wen,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      ex_redirect,
  output logic                      stall_if,
  output logic                      stall_id,
  output logic                      flush_id,
  output logic                      bubble_ex,
  output logic                      hold_mem,
  output logic [1:0]                fwd_rs1,
  output logic [1:0]                fwd_rs2,
  output logic                      mem_timeout,
  output logic [PERF_W-1:0]         stall_cycles
);

  localparam logic [TIMEOUT_W-1:0] WAIT_MAX = '1;

  logic [1:0]           state, state_nxt;
  logic [TIMEOUT_W-1:0] wait_cnt, wait_nxt;
  logic                 pending, pending_nxt;
  logic                 timeout_nxt;
  logic                 c_stall, c_flush, c_bubble, c_hold;
  logic [1:0]           c_fwd1, c_fwd2;
  logic                 lu1, lu2, load_use;

  hazard_fwd_sel #(.AW(REG_ADDR_WIDTH)) u_sel_rs1 (
    .id_valid(id_valid), .rs(id_rs1), .use_rs(id_use_rs1),
    .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
    .mem_ready(mem_ready), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
    .fwd(c_fwd1), .load_use(lu1)
  );

  hazard_fwd_sel #(.AW(REG_ADDR_WIDTH)) u_sel_rs2 (
    .id_valid(id_valid), .rs(id_rs2), .use_rs(id_use_rs2),
    .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
    .mem_ready(mem_ready), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
    .fwd(c_fwd2), .load_use(lu2)
  );

  assign load_use = lu1 | lu2;

  // Control decode and next-state; wait_cnt holds the number of wait cycles already spent
  always_comb begin
    c_stall     = 1'b0;
    c_flush     = 1'b0;
    c_bubble    = 1'b0;
    c_hold      = 1'b0;
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    pending_nxt = pending;
    timeout_nxt = mem_timeout;
    case (state)
      ST_RUN: begin
        if (mem_valid && mem_req && !mem_ready) begin
          c_stall   = 1'b1;
          c_hold    = 1'b1;
          c_bubble  = 1'b1;
          state_nxt = ST_MEM_WAIT;
          wait_nxt  = TIMEOUT_W'(1);
          if (ex_redirect) pending_nxt = 1'b1;
        end else if (ex_redirect) begin
          c_flush  = 1'b1;
          c_bubble = 1'b1;
        end else if (load_use) begin
          c_stall  = 1'b1;
          c_bubble = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt   = ST_RUN;
          wait_nxt    = '0;
          pending_nxt = 1'b0;
          if (pending || ex_redirect) begin
            c_flush  = 1'b1;
            c_bubble = 1'b1;
          end else if (load_use) begin
            c_stall  = 1'b1;
            c_bubble = 1'b1;
          end
        end else begin
          c_stall     = 1'b1;
          c_hold      = 1'b1;
          c_bubble    = 1'b1;
          pending_nxt = pending | ex_redirect;
          if (wait_cnt >= WAIT_MAX - 1'b1) begin
            state_nxt   = ST_TIMEOUT;
            timeout_nxt = 1'b1;
            wait_nxt    = WAIT_MAX;
          end else begin
            wait_nxt = wait_cnt + 1'b1;
          end
        end
      end
      ST_TIMEOUT: begin
        c_stall  = 1'b1;
        c_hold   = 1'b1;
        c_bubble = 1'b1;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // State, wait counter, pending redirect, sticky timeout and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      wait_cnt     <= '0;
      pending      <= 1'b0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      pending     <= pending_nxt;
      mem_timeout <= timeout_nxt;
      if (c_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
    end
  end

  assign stall_if  = rst_n & c_stall;
  assign stall_id  = rst_n & c_stall;
  assign flush_id  = rst_n & c_flush;
  assign bubble_ex = rst_n & c_bubble;
  assign hold_mem  = rst_n & c_hold;
  assign fwd_rs1   = rst_n ? c_fwd1 : FWD_RF;
  assign fwd_rs2   = rst_n ? c_fwd2 : FWD_RF;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2;
  logic       id_use_rs1, id_use_rs2;
  logic       ex_valid, ex_wen, ex_is_load;
  logic [4:0] ex_rd;
  logic       mem_valid, mem_wen, mem_is_load;
  logic [4:0] mem_rd;
  logic       mem_req, mem_ready;
  logic       wb_valid, wb_wen;
  logic [4:0] wb_rd;
  logic       ex_redirect;
  logic       stall_if, stall_id, flush_id, bubble_ex, hold_mem;
  logic [1:0] fwd_rs1, fwd_rs2;
  logic       mem_timeout;
  logic [3:0] stall_cycles;

  int n_checks;
  int n_pass;

  pipe_hazard_ctrl #(.REG_ADDR_WIDTH(5), .TIMEOUT_W(3), .PERF_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_is_load(mem_is_load), .mem_rd(mem_rd),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
    .ex_redirect(ex_redirect),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
    .bubble_ex(bubble_ex), .hold_mem(hold_mem),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_valid = 0; ex_wen = 0; ex_is_load = 0; ex_rd = 0;
    mem_valid = 0; mem_wen = 0; mem_is_load = 0; mem_rd = 0;
    mem_req = 0; mem_ready = 0;
    wb_valid = 0; wb_wen = 0; wb_rd = 0;
    ex_redirect = 0;
  endtask

  // advance one clock and return at the following falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_n = 0;
    #1;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic start_mem_stall();
    mem_valid = 1; mem_wen = 1; mem_rd = 5'd9; mem_req = 1; mem_ready = 0;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    idle();
    rst_n = 0;
    // reset with hazard-provoking inputs: every control output must stay low
    id_valid = 1; id_rs1 = 5'd5; id_use_rs1 = 1;
    ex_valid = 1; ex_wen = 1; ex_rd = 5'd5; ex_redirect = 1;
    #2;
    check("rst_fwd_rs1", fwd_rs1, 0);
    check("rst_flush_id", flush_id, 0);
    check("rst_bubble_ex", bubble_ex, 0);
    check("rst_stall_cycles", stall_cycles, 0);
    check("rst_mem_timeout", mem_timeout, 0);
    @(negedge clk);
    rst_n = 1;
    idle();

    // ALU result in EX forwarded to both operands
    id_valid = 1; id_rs1 = 5'd5; id_rs2 = 5'd5; id_use_rs1 = 1; id_use_rs2 = 1;
    ex_valid = 1; ex_wen = 1; ex_rd = 5'd5;
    #1;
    check("ex_fwd_rs1", fwd_rs1, 1);
    check("ex_fwd_rs2", fwd_rs2, 1);
    check("ex_fwd_no_stall", stall_id, 0);
    // x0 never forwards
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    #1;
    check("x0_fwd_rs1", fwd_rs1, 0);
    check("x0_fwd_rs2", fwd_rs2, 0);
    // priority EX over MEM, WB on the other operand, use_rs gating
    ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd6;
    mem_valid = 1; mem_wen = 1; mem_rd = 5'd5;
    wb_valid = 1; wb_wen = 1; wb_rd = 5'd6;
    #1;
    check("prio_ex_over_mem", fwd_rs1, 1);
    check("wb_fwd_rs2", fwd_rs2, 3);
    ex_valid = 0;
    #1;
    check("mem_over_regfile", fwd_rs1, 2);
    id_use_rs2 = 0;
    #1;
    check("use_rs2_off", fwd_rs2, 0);

    // load-use: one stall cycle, then MEM forwarding once the load data is ready
    @(negedge clk);
    idle();
    id_valid = 1; id_rs2 = 5'd7; id_use_rs2 = 1;
    ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_rd = 5'd7;
    #1;
    check("lu_stall_if", stall_if, 1);
    check("lu_stall_id", stall_id, 1);
    check("lu_bubble_ex", bubble_ex, 1);
    check("lu_flush_id", flush_id, 0);
    check("lu_hold_mem", hold_mem, 0);
    tick();
    ex_valid = 0; ex_wen = 0; ex_is_load = 0; ex_rd = 0;
    mem_valid = 1; mem_wen = 1; mem_is_load = 1; mem_rd = 5'd7; mem_req = 1; mem_ready = 1;
    #1;
    check("lu_next_fwd_rs2", fwd_rs2, 2);
    check("lu_next_stall_id", stall_id, 0);
    check("lu_stall_cycles", stall_cycles, 1);
    // ready without a request changes nothing
    mem_req = 0; mem_is_load = 0;
    #1;
    check("ready_no_req_hold", hold_mem, 0);

    // memory wait of three cycles
    @(negedge clk);
    idle();
    reset_pulse();
    start_mem_stall();
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("wait_hold_%0d", i), hold_mem, 1);
      check($sformatf("wait_stall_if_%0d", i), stall_if, 1);
      tick();
    end
    mem_ready = 1;
    #1;
    check("wait_ready_hold", hold_mem, 0);
    check("wait_ready_stall_id", stall_id, 0);
    check("wait_ready_flush", flush_id, 0);
    tick();
    idle();
    ex_redirect = 1;
    #1;
    check("wait_stall_cycles", stall_cycles, 3);
    check("wait_back_run_flush", flush_id, 1);

    // redirect arriving with the stall start is deferred to the ready cycle
    @(negedge clk);
    idle();
    start_mem_stall();
    ex_redirect = 1;
    #1;
    check("pr_start_flush", flush_id, 0);
    check("pr_start_stall", stall_id, 1);
    tick();
    ex_redirect = 0;
    #1;
    check("pr_wait_flush", flush_id, 0);
    tick();
    mem_ready = 1;
    #1;
    check("pr_ready_flush", flush_id, 1);
    check("pr_ready_bubble", bubble_ex, 1);
    check("pr_ready_hold", hold_mem, 0);
    check("pr_ready_stall_if", stall_if, 0);
    tick();
    // a fresh stall that completes must not replay the old redirect
    mem_ready = 0;
    tick();
    mem_ready = 1;
    #1;
    check("pr_cleared_flush", flush_id, 0);

    // redirect and load-use together: wrong-path ID, no stall
    @(negedge clk);
    idle();
    id_valid = 1; id_rs2 = 5'd7; id_use_rs2 = 1;
    ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_rd = 5'd7; ex_redirect = 1;
    #1;
    check("rl_flush_id", flush_id, 1);
    check("rl_bubble_ex", bubble_ex, 1);
    check("rl_stall_if", stall_if, 0);
    check("rl_stall_id", stall_id, 0);

    // timeout after 7 wait cycles with TIMEOUT_W=3
    @(negedge clk);
    idle();
    reset_pulse();
    start_mem_stall();
    for (int i = 0; i < 6; i++) tick();
    #1;
    check("to_before_limit", mem_timeout, 0);
    tick();
    #1;
    check("to_fired", mem_timeout, 1);
    mem_ready = 1;
    #1;
    check("to_ready_hold", hold_mem, 1);
    check("to_ready_stall_id", stall_id, 1);
    for (int i = 0; i < 12; i++) tick();
    #1;
    check("to_sticky", mem_timeout, 1);
    check("to_stall_saturate", stall_cycles, 15);
    rst_n = 0;
    #1;
    check("to_rst_timeout", mem_timeout, 0);
    check("to_rst_stall_cycles", stall_cycles, 0);
    check("to_rst_hold", hold_mem, 0);
    @(negedge clk);
    rst_n = 1;
    idle();
    #1;
    check("post_rst_hold", hold_mem, 0);
    check("post_rst_stall", stall_id, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
